// File: rtl/uart_rx_word_packer.sv
// Packs NBYTES consecutive UART bytes (first byte in the LSBs) into one word with a valid/ready output.
// Optional inter-byte timeout that discards stale partial words: define UART_PACK_TIMEOUT_EN.
module uart_rx_word_packer #(
   parameter int NBITS         = 8,
   parameter int NBYTES        = 4,
   parameter int TIMEOUT_TICKS = 320
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_baud_rate,
   input  logic                      i_rx_done,
   input  logic [NBITS-1:0]          i_data,
   input  logic                      i_ready,
   input  logic                      i_clr_overflow,
   output logic                      o_valid,
   output logic [NBITS*NBYTES-1:0]   o_word,
   output logic [$clog2(NBYTES):0]   o_byte_count,
   output logic                      o_overflow,
   output logic                      o_timeout
);
   localparam int CW = $clog2(NBYTES) + 1;
   localparam int WW = NBITS * NBYTES;

   typedef enum logic {S_COLLECT, S_FULL} state_t;

   state_t          r_state, w_state_next;
   logic [CW-1:0]   r_count, w_count_next;
   logic [WW-1:0]   r_assembly, w_assembly_next;
   logic [WW-1:0]   r_word, w_word_next;
   logic            r_valid, w_valid_next;
   logic            r_overflow, w_overflow_next;
   logic            w_slot_free;
   logic            w_last;
   logic            w_set_ovf;
   logic [WW-1:0]   w_filled;

`ifdef UART_PACK_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_TICKS) + 1;
   logic [TW-1:0]   r_tmo_cnt, w_tmo_cnt_next;
   logic            r_timeout;
   logic            w_tmo_window;
   logic            w_expire;

   // Silence is only timed while a partial word is being assembled; any new byte restarts it.
   always_comb begin
      w_tmo_window   = (r_state == S_COLLECT) && (r_count != '0);
      w_expire       = w_tmo_window && i_baud_rate && !i_rx_done &&
                       (r_tmo_cnt == TW'(TIMEOUT_TICKS - 1));
      w_tmo_cnt_next = r_tmo_cnt;
      if (!w_tmo_window || i_rx_done || w_expire)
         w_tmo_cnt_next = '0;
      else if (i_baud_rate)
         w_tmo_cnt_next = r_tmo_cnt + TW'(1);
   end

   assign o_timeout = r_timeout;
`else
   logic w_unused_baud;
   assign w_unused_baud = i_baud_rate & (TIMEOUT_TICKS > 0);
   assign o_timeout     = 1'b0;
`endif

   assign w_slot_free = !r_valid || i_ready;
   assign w_last      = (r_count == CW'(NBYTES - 1));

   always_comb begin
      w_filled = r_assembly;
      for (int k = 0; k < NBYTES; k++) begin
         if (r_count == CW'(k))
            w_filled[k*NBITS +: NBITS] = i_data;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_count_next    = r_count;
      w_assembly_next = r_assembly;
      w_word_next     = r_word;
      w_valid_next    = r_valid;
      w_set_ovf       = 1'b0;
      case (r_state)
         S_COLLECT: begin
            if (r_valid && i_ready)
               w_valid_next = 1'b0;
            if (i_rx_done) begin
               if (w_last && w_slot_free) begin
                  w_word_next     = w_filled;
                  w_valid_next    = 1'b1;
                  w_count_next    = '0;
                  w_assembly_next = '0;
               end else if (w_last) begin
                  w_assembly_next = w_filled;
                  w_count_next    = CW'(NBYTES);
                  w_state_next    = S_FULL;
               end else begin
                  w_assembly_next = w_filled;
                  w_count_next    = r_count + CW'(1);
               end
            end
`ifdef UART_PACK_TIMEOUT_EN
            else if (w_expire) begin
               w_count_next    = '0;
               w_assembly_next = '0;
            end
`endif
         end
         S_FULL: begin
            if (w_slot_free) begin
               w_word_next     = r_assembly;
               w_valid_next    = 1'b1;
               w_state_next    = S_COLLECT;
               w_assembly_next = '0;
               w_count_next    = '0;
               // A byte arriving on the draining edge starts the next word.
               if (i_rx_done) begin
                  w_assembly_next[NBITS-1:0] = i_data;
                  w_count_next               = CW'(1);
               end
            end else if (i_rx_done) begin
               w_set_ovf = 1'b1;
            end
         end
         default: w_state_next = S_COLLECT;
      endcase
      w_overflow_next = w_set_ovf || (r_overflow && !i_clr_overflow);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_COLLECT;
         r_count    <= '0;
         r_assembly <= '0;
         r_word     <= '0;
         r_valid    <= 1'b0;
         r_overflow <= 1'b0;
`ifdef UART_PACK_TIMEOUT_EN
         r_tmo_cnt  <= '0;
         r_timeout  <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_next;
         r_count    <= w_count_next;
         r_assembly <= w_assembly_next;
         r_word     <= w_word_next;
         r_valid    <= w_valid_next;
         r_overflow <= w_overflow_next;
`ifdef UART_PACK_TIMEOUT_EN
         r_tmo_cnt  <= w_tmo_cnt_next;
         r_timeout  <= w_expire;
`endif
      end
   end

   assign o_valid      = r_valid;
   assign o_word       = r_word;
   assign o_byte_count = r_count;
   assign o_overflow   = r_overflow;
endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Self-checking bench for uart_rx_word_packer: vector table, hand sequences and a randomized run
// against a queue-based reference model. Timeout checks follow UART_PACK_TIMEOUT_EN.
module tb_uart_rx_word_packer;
   localparam int NB = 4;
   localparam int BITS = 8;
   localparam int TT = 320;
`ifdef UART_PACK_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_baud_rate = 1'b0;
   logic        i_rx_done = 1'b0;
   logic [7:0]  i_data = '0;
   logic        i_ready = 1'b0;
   logic        i_clr_overflow = 1'b0;
   logic        o_valid;
   logic [31:0] o_word;
   logic [2:0]  o_byte_count;
   logic        o_overflow;
   logic        o_timeout;

   int n_cmp = 0;
   int n_bad = 0;

   uart_rx_word_packer #(.NBITS(BITS), .NBYTES(NB), .TIMEOUT_TICKS(TT)) dut (
      .clk(clk), .rst(rst), .i_baud_rate(i_baud_rate), .i_rx_done(i_rx_done),
      .i_data(i_data), .i_ready(i_ready), .i_clr_overflow(i_clr_overflow),
      .o_valid(o_valid), .o_word(o_word), .o_byte_count(o_byte_count),
      .o_overflow(o_overflow), .o_timeout(o_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        done;
      logic [7:0]  data;
      logic        ready;
      logic        clr;
      logic        exp_valid;
      logic [31:0] exp_word;
      logic [2:0]  exp_count;
      logic        exp_ovf;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic d, input logic [7:0] dat, input logic rdy, input logic clr,
                               input logic ev, input logic [31:0] ew, input logic [2:0] ec, input logic eo);
      vec_t v;
      v.done = d; v.data = dat; v.ready = rdy; v.clr = clr;
      v.exp_valid = ev; v.exp_word = ew; v.exp_count = ec; v.exp_ovf = eo;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_rx_done = 1'b0; i_baud_rate = 1'b0; i_clr_overflow = 1'b0; i_data = '0;
   endtask

   task automatic send(input logic [7:0] b);
      i_rx_done = 1'b1; i_data = b;
      step();
      i_rx_done = 1'b0;
   endtask

   // Reference model: bytes held as a queue, one pending output word.
   logic [7:0]  m_q[$];
   logic [31:0] m_word;
   bit          m_valid, m_full, m_ovf, m_tmo;
   int          m_ticks;

   function automatic logic [31:0] pack_q();
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < m_q.size(); i++) w[i*8 +: 8] = m_q[i];
      return w;
   endfunction

   task automatic model_reset();
      m_q.delete(); m_word = '0; m_valid = 0; m_full = 0; m_ovf = 0; m_tmo = 0; m_ticks = 0;
   endtask

   task automatic model_cycle(input bit done, input logic [7:0] data, input bit ready,
                              input bit clr, input bit baud);
      bit sf;
      bit drop;
      int sz;
      sf = !m_valid || ready;
      drop = 0;
      m_tmo = 0;
      sz = m_q.size();
      if (m_full) begin
         if (sf) begin
            m_word = pack_q(); m_valid = 1; m_q.delete(); m_full = 0;
            $display("model word %08h", m_word);
            if (done) m_q.push_back(data);
         end else if (done) begin
            drop = 1;
         end
      end else begin
         if (m_valid && ready) m_valid = 0;
         if (done) begin
            m_q.push_back(data);
            if (m_q.size() == NB) begin
               if (sf) begin
                  m_word = pack_q(); m_valid = 1; m_q.delete();
                  $display("model word %08h", m_word);
               end else begin
                  m_full = 1;
               end
            end
         end else if (TMO_EN && baud && sz > 0) begin
            m_ticks++;
            if (m_ticks == TT) begin
               m_q.delete(); m_tmo = 1;
            end
         end
      end
      if (done || m_q.size() == 0 || m_full) m_ticks = 0;
      if (clr) m_ovf = 0;
      if (drop) m_ovf = 1;
   endtask

   task automatic do_reset();
      idle_inputs();
      i_ready = 1'b0;
      rst = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      step();
      model_reset();
   endtask

   initial begin
      int tmo_seen;
      logic [31:0] first_word;
      bit got_word;
      bit b_done, b_ready, b_clr, b_baud;
      logic [7:0] b_data;
      int quiet;

      // Asynchronous reset state
      #2 rst = 1'b0;
      #1;
      check("rst_valid", 64'(o_valid), 64'(0));
      check("rst_word", 64'(o_word), 64'(0));
      check("rst_count", 64'(o_byte_count), 64'(0));
      check("rst_ovf", 64'(o_overflow), 64'(0));
      check("rst_tmo", 64'(o_timeout), 64'(0));
      repeat (2) step();
      rst = 1'b1;
      step();

      // done data rdy clr | valid word count ovf
      vq.push_back(mk(1, 8'h11, 1, 0, 0, 32'h0, 3'd1, 0));
      vq.push_back(mk(1, 8'h22, 1, 0, 0, 32'h0, 3'd2, 0));
      vq.push_back(mk(1, 8'h33, 1, 0, 0, 32'h0, 3'd3, 0));
      vq.push_back(mk(1, 8'h44, 1, 0, 1, 32'h44332211, 3'd0, 0));
      vq.push_back(mk(0, 8'h00, 1, 0, 0, 32'h44332211, 3'd0, 0));
      vq.push_back(mk(1, 8'h01, 0, 0, 0, 32'h44332211, 3'd1, 0));
      vq.push_back(mk(1, 8'h02, 0, 0, 0, 32'h44332211, 3'd2, 0));
      vq.push_back(mk(1, 8'h03, 0, 0, 0, 32'h44332211, 3'd3, 0));
      vq.push_back(mk(1, 8'h04, 0, 0, 1, 32'h04030201, 3'd0, 0));
      vq.push_back(mk(1, 8'h05, 0, 0, 1, 32'h04030201, 3'd1, 0));
      vq.push_back(mk(1, 8'h06, 0, 0, 1, 32'h04030201, 3'd2, 0));
      vq.push_back(mk(1, 8'h07, 0, 0, 1, 32'h04030201, 3'd3, 0));
      vq.push_back(mk(1, 8'h08, 0, 0, 1, 32'h04030201, 3'd4, 0));
      vq.push_back(mk(1, 8'h09, 0, 1, 1, 32'h04030201, 3'd4, 1));
      vq.push_back(mk(0, 8'h00, 1, 0, 1, 32'h08070605, 3'd0, 1));
      vq.push_back(mk(0, 8'h00, 1, 0, 0, 32'h08070605, 3'd0, 1));
      vq.push_back(mk(0, 8'h00, 0, 1, 0, 32'h08070605, 3'd0, 0));
      vq.push_back(mk(1, 8'h10, 0, 0, 0, 32'h08070605, 3'd1, 0));
      vq.push_back(mk(1, 8'h20, 0, 0, 0, 32'h08070605, 3'd2, 0));
      vq.push_back(mk(1, 8'h30, 0, 0, 0, 32'h08070605, 3'd3, 0));
      vq.push_back(mk(1, 8'h40, 0, 0, 1, 32'h40302010, 3'd0, 0));
      vq.push_back(mk(1, 8'h50, 0, 0, 1, 32'h40302010, 3'd1, 0));
      vq.push_back(mk(1, 8'h60, 0, 0, 1, 32'h40302010, 3'd2, 0));
      vq.push_back(mk(1, 8'h70, 0, 0, 1, 32'h40302010, 3'd3, 0));
      vq.push_back(mk(1, 8'h80, 0, 0, 1, 32'h40302010, 3'd4, 0));
      vq.push_back(mk(1, 8'hAA, 1, 0, 1, 32'h80706050, 3'd1, 0));
      vq.push_back(mk(1, 8'hBB, 0, 0, 1, 32'h80706050, 3'd2, 0));
      vq.push_back(mk(1, 8'hCC, 0, 0, 1, 32'h80706050, 3'd3, 0));
      vq.push_back(mk(1, 8'hDD, 0, 0, 1, 32'h80706050, 3'd4, 0));
      vq.push_back(mk(0, 8'h00, 1, 0, 1, 32'hDDCCBBAA, 3'd0, 0));
      vq.push_back(mk(0, 8'h00, 1, 0, 0, 32'hDDCCBBAA, 3'd0, 0));

      for (int i = 0; i < vq.size(); i++) begin
         i_rx_done = vq[i].done; i_data = vq[i].data;
         i_ready = vq[i].ready; i_clr_overflow = vq[i].clr;
         step();
         $display("vec %0d: valid=%0b word=%08h count=%0d ovf=%0b", i, o_valid, o_word, o_byte_count, o_overflow);
         check($sformatf("vec%0d_valid", i), 64'(o_valid), 64'(vq[i].exp_valid));
         check($sformatf("vec%0d_word", i), 64'(o_word), 64'(vq[i].exp_word));
         check($sformatf("vec%0d_count", i), 64'(o_byte_count), 64'(vq[i].exp_count));
         check($sformatf("vec%0d_ovf", i), 64'(o_overflow), 64'(vq[i].exp_ovf));
         check($sformatf("vec%0d_tmo", i), 64'(o_timeout), 64'(0));
      end
      idle_inputs();

      // Reset in the middle of a word
      i_ready = 1'b1;
      send(8'h55); send(8'h66);
      check("mid_count", 64'(o_byte_count), 64'(2));
      rst = 1'b0;
      #1;
      check("arst_word", 64'(o_word), 64'(0));
      check("arst_count", 64'(o_byte_count), 64'(0));
      check("arst_valid", 64'(o_valid), 64'(0));
      repeat (2) step();
      rst = 1'b1;
      step();
      send(8'hA1); send(8'hA2); send(8'hA3);
      check("post_rst_novalid", 64'(o_valid), 64'(0));
      send(8'hA4);
      $display("post-reset word: valid=%0b word=%08h", o_valid, o_word);
      check("post_rst_valid", 64'(o_valid), 64'(1));
      check("post_rst_word", 64'(o_word), 64'(32'hA4A3A2A1));

      // Idle timeout on a partial word
      do_reset();
      i_ready = 1'b1;
      send(8'hB1); send(8'hB2);
      tmo_seen = 0;
      i_baud_rate = 1'b1;
      for (int t = 0; t < TT; t++) begin
         step();
         if (o_timeout) tmo_seen++;
      end
      check("tmo_at_expiry", 64'(o_timeout), 64'(TMO_EN));
      i_baud_rate = 1'b0;
      check("tmo_count", 64'(o_byte_count), 64'(TMO_EN ? 0 : 2));
      check("tmo_pulses", 64'(tmo_seen), 64'(TMO_EN ? 1 : 0));
      step();
      check("tmo_one_cycle", 64'(o_timeout), 64'(0));
      got_word = 0; first_word = '0;
      for (int b = 1; b <= 4; b++) begin
         send(8'hC0 + 8'(b));
         if (o_valid && !got_word) begin got_word = 1; first_word = o_word; end
      end
      $display("after timeout: word=%08h count=%0d", first_word, o_byte_count);
      check("tmo_next_word", 64'(first_word), 64'(TMO_EN ? 32'hC4C3C2C1 : 32'hC2C1B2B1));
      check("tmo_next_count", 64'(o_byte_count), 64'(TMO_EN ? 0 : 2));

`ifdef UART_PACK_TIMEOUT_EN
      // Final byte lands on the expiry tick: the byte wins
      do_reset();
      i_ready = 1'b1;
      send(8'hD1); send(8'hD2); send(8'hD3);
      tmo_seen = 0;
      i_baud_rate = 1'b1;
      for (int t = 0; t < TT - 1; t++) begin
         step();
         if (o_timeout) tmo_seen++;
      end
      i_rx_done = 1'b1; i_data = 8'hD4;
      step();
      if (o_timeout) tmo_seen++;
      idle_inputs();
      $display("expiry race: valid=%0b word=%08h", o_valid, o_word);
      check("race_no_tmo", 64'(tmo_seen), 64'(0));
      check("race_valid", 64'(o_valid), 64'(1));
      check("race_word", 64'(o_word), 64'(32'hD4D3D2D1));
      step();
      check("race_tmo_after", 64'(o_timeout), 64'(0));
`endif

      // Randomized run against the reference model
      do_reset();
      quiet = 0;
      for (int c = 0; c < 3000; c++) begin
         if (quiet == 0 && $urandom_range(0, 149) == 0) quiet = 340;
         b_done  = (quiet > 0) ? 1'b0 : ($urandom_range(0, 2) == 0);
         b_baud  = (quiet > 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
         b_ready = ($urandom_range(0, 1) == 0);
         b_clr   = ($urandom_range(0, 15) == 0);
         b_data  = 8'($urandom);
         if (quiet > 0) quiet--;
         i_rx_done = b_done; i_baud_rate = b_baud; i_ready = b_ready;
         i_clr_overflow = b_clr; i_data = b_data;
         model_cycle(b_done, b_data, b_ready, b_clr, b_baud);
         step();
         check("rnd_valid", 64'(o_valid), 64'(m_valid));
         check("rnd_word", 64'(o_word), 64'(m_word));
         check("rnd_count", 64'(o_byte_count), 64'(m_full ? NB : m_q.size()));
         check("rnd_ovf", 64'(o_overflow), 64'(m_ovf));
         check("rnd_tmo", 64'(o_timeout), 64'(m_tmo));
      end
      idle_inputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_rx_word_packer.md
Name: uart_rx_word_packer

Overview:
- Sits directly downstream of the UART receiver in the DebugUnit.
- Consumes the receiver's one-cycle byte-done pulse plus data byte.
- Packs NBYTES consecutive bytes into one word for the debug command decoder, using a valid/ready output handshake.
- Provides one-word output buffering, a sticky overflow flag and an optional inter-byte timeout that discards stale partial words.

Parameters:
- NBITS, 8: bits per received byte; must match the receiver.
- NBYTES, 4: bytes per output word (≥2).
- TIMEOUT_TICKS, 320: baud ticks (16 per bit) of silence that abort a partial word; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- i_baud_rate  in  1  16x-oversample tick from the baud generator.
- i_rx_done  in  1  one-cycle pulse: i_data holds a new byte.
- i_data  in  NBITS  received byte.
- i_ready  in  1  consumer accepts o_word this cycle.
- i_clr_overflow  in  1  clears o_overflow.
- o_valid  out  1  o_word holds an unconsumed word.
- o_word  out  NBITS*NBYTES  packed word.
- o_byte_count  out  $clog2(NBYTES)+1  bytes currently held in the assembly register (0..NBYTES).
- o_overflow  out  1  sticky: a byte was dropped.
- o_timeout  out  1  one-cycle pulse: partial word discarded.

Behaviour:
- Reset (rst low, async): state COLLECT, count 0, assembly 0, timeout counter 0. Outputs o_word 0, o_valid 0, o_overflow 0, o_timeout 0.
- Byte order: first byte received goes to o_word[NBITS-1:0]; byte k goes to bits [k*NBITS +: NBITS].
- Output slot free ("slot_free") when !o_valid || i_ready.
- Handshake:
  - Transfer occurs at an edge where o_valid && i_ready.
  - o_valid stays high and o_word stays stable until transfer.
  - o_valid never drops without i_ready.
- State COLLECT (count < NBYTES):
  - On i_rx_done, write i_data into slot count and increment count.
  - If that byte is byte NBYTES-1 and slot_free: o_word <= completed word, o_valid <= 1, count <= 0, stay in COLLECT. o_valid is high the cycle after the final i_rx_done (1-cycle latency).
  - If that byte is byte NBYTES-1 and the slot is not free: count <= NBYTES, go to FULL.
- State FULL (assembly complete, o_valid high):
  - At the first edge with slot_free, load o_word, keep o_valid 1, count <= 0, go to COLLECT.
  - i_rx_done with slot_free in the same cycle: the transfer happens and the new byte becomes byte 0 of the next word (count 1). No overflow.
  - i_rx_done without slot_free: byte dropped, o_overflow <= 1, assembly unchanged.
- o_overflow: sticky. Cleared by i_clr_overflow. If set and clear coincide, set wins.
- o_byte_count: equals registered count (NBYTES while in FULL).
- o_timeout: 0 when the feature is absent.
- Reset mid-word: any partial or pending word is lost. No o_valid after reset until a full NBYTES new bytes arrive.

Optional Feature:
Macro: UART_PACK_TIMEOUT_EN
- Defined:
  - A counter (width $clog2(TIMEOUT_TICKS)+1) increments on i_baud_rate while in COLLECT with 1 ≤ count ≤ NBYTES-1.
  - It clears to 0 on each i_rx_done and whenever count is 0.
  - On reaching TIMEOUT_TICKS: count <= 0, assembly cleared, counter <= 0, o_timeout high for exactly one cycle.
  - If i_rx_done coincides with expiry, the byte wins: it is stored, the counter clears, and there is no timeout.
  - The timeout is inactive in FULL.
- Not defined: no counter logic. o_timeout is tied 0. Partial words persist indefinitely.

Test Plan:
- i_ready=1; bytes 0x11,0x22,0x33,0x44 → o_valid high exactly one cycle, starting the cycle after the 4th i_rx_done; o_word=0x44332211; o_byte_count returns to 0.
- i_ready=0; send 8 bytes 0x01..0x08 → o_word=0x04030201 held; o_byte_count=4 (FULL). 9th byte 0x09 → o_overflow=1, byte dropped. Raise i_ready → 0x04030201 then 0x08070605 delivered in order; then pulse i_clr_overflow → o_overflow=0.
- In FULL with i_ready rising in the same cycle as i_rx_done with 0xAA → word transferred, o_overflow stays 0, o_byte_count=1. Next 3 bytes 0xBB,0xCC,0xDD → 0xDDCCBBAA.
- Send 0x55,0x66, then drive rst low for 2 cycles → all outputs 0, count 0. Then bytes 0xA1..0xA4 → o_word=0xA4A3A2A1.
- With UART_PACK_TIMEOUT_EN: 2 bytes then 320 idle baud ticks → one o_timeout pulse, o_byte_count=0. Next 4 bytes form a clean word. Without the macro, same stimulus → o_byte_count stays 2, o_timeout stays 0.
- With UART_PACK_TIMEOUT_EN: 3 bytes; 4th i_rx_done lands on the expiry tick → no o_timeout, word delivered normally.
